// File: rtl/bch_pkg.sv
// Shared types and constants for the BCH(31,16) t=3 decoder controller.
// The optional per-stage watchdog is enabled by defining BCH_CTRL_TIMEOUT_EN.
package bch_pkg;

  localparam int BCH_N          = 31;
  localparam int BCH_M          = 5;
  localparam int BCH_T          = 3;
  localparam int BCH_TMO_CYCLES = 255;

  typedef enum logic [2:0] {
    IDLE,
    SYN,
    BM,
    CHIEN,
    OUT
  } bch_ctrl_state_t;

  typedef struct packed {
    logic [3:0] nerr;
    logic       fail;
  } bch_status_t;

  localparam bch_status_t STATUS_FAIL = '{nerr: 4'd0, fail: 1'b1};

  function automatic bch_status_t status_ok(input logic [3:0] nerr);
    return '{nerr: nerr, fail: 1'b0};
  endfunction

endpackage

// File: rtl/bch_stage_timer.sv
// Per-stage watchdog: cleared by any start pulse, counts while a stage waits.
// Only instantiated when BCH_CTRL_TIMEOUT_EN is defined.
module bch_stage_timer
  import bch_pkg::*;
#(
  parameter int TMO_CYCLES = BCH_TMO_CYCLES
)
(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [7:0] cnt;

  // cnt equals the number of cycles elapsed since the start pulse, so expire
  // marks the cycle on whose closing edge the count reaches TMO_CYCLES.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 8'd0;
    end else if (clear) begin
      cnt <= 8'd1;
    end else if (enable && cnt != 8'hff) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign expire = enable && !clear && (cnt == 8'(TMO_CYCLES - 1));

endmodule

// File: rtl/bch_decode_ctrl.sv
// Sequencer for the BCH(31,16) decoder: syndrome -> Berlekamp-Massey -> Chien.
// Define BCH_CTRL_TIMEOUT_EN to add a per-stage watchdog (TMO_CYCLES).
module bch_decode_ctrl
  import bch_pkg::*;
#(
  parameter int TMO_CYCLES = BCH_TMO_CYCLES
)
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BCH_N-1:0] in_word,
  output logic             syn_start,
  input  logic             syn_done,
  input  logic             syn_zero,
  output logic             bm_start,
  input  logic             bm_done,
  input  logic [3:0]       bm_L,
  output logic             chien_start,
  input  logic             chien_done,
  input  logic [3:0]       chien_nroots,
  output logic [BCH_N-1:0] word_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_nerr,
  output logic             out_fail,
  output logic             busy
);

  bch_ctrl_state_t  state_q, state_d;
  bch_status_t      status_q, status_d;
  logic [BCH_N-1:0] word_d;
  logic [3:0]       l_q, l_d;
  logic             syn_start_d, bm_start_d, chien_start_d;
  logic             tmo_expire;

`ifdef BCH_CTRL_TIMEOUT_EN
  bch_stage_timer #(.TMO_CYCLES(TMO_CYCLES)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (syn_start | bm_start | chien_start),
    .enable (state_q == SYN || state_q == BM || state_q == CHIEN),
    .expire (tmo_expire)
  );
`else
  assign tmo_expire = 1'b0;
`endif

  // NOTE: every variable gets its default before the case so that no path
  // leaves one unassigned; that is what keeps this block free of latches.
  always_comb begin
    state_d       = state_q;
    status_d      = status_q;
    word_d        = word_q;
    l_d           = l_q;
    syn_start_d   = 1'b0;
    bm_start_d    = 1'b0;
    chien_start_d = 1'b0;
    unique case (state_q)
      IDLE: if (in_valid) begin
        word_d      = in_word;
        syn_start_d = 1'b1;
        state_d     = SYN;
      end
      // A done seen while its own start pulse is still high is stale.
      SYN: if (syn_done && !syn_start) begin
        if (syn_zero) begin
          status_d = status_ok(4'd0);
          state_d  = OUT;
        end else begin
          bm_start_d = 1'b1;
          state_d    = BM;
        end
      end else if (tmo_expire) begin
        status_d = STATUS_FAIL;
        state_d  = OUT;
      end
      BM: if (bm_done && !bm_start) begin
        if (bm_L == 4'd0 || bm_L > 4'(BCH_T)) begin
          status_d = STATUS_FAIL;
          state_d  = OUT;
        end else begin
          l_d           = bm_L;
          chien_start_d = 1'b1;
          state_d       = CHIEN;
        end
      end else if (tmo_expire) begin
        status_d = STATUS_FAIL;
        state_d  = OUT;
      end
      CHIEN: if (chien_done && !chien_start) begin
        status_d = (chien_nroots == l_q) ? status_ok(l_q) : STATUS_FAIL;
        state_d  = OUT;
      end else if (tmo_expire) begin
        status_d = STATUS_FAIL;
        state_d  = OUT;
      end
      OUT: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      status_q    <= '0;
      word_q      <= '0;
      l_q         <= 4'd0;
      syn_start   <= 1'b0;
      bm_start    <= 1'b0;
      chien_start <= 1'b0;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      word_q      <= word_d;
      l_q         <= l_d;
      syn_start   <= syn_start_d;
      bm_start    <= bm_start_d;
      chien_start <= chien_start_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == OUT);
  assign out_nerr  = status_q.nerr;
  assign out_fail  = status_q.fail;

endmodule
